// File: rtl/flash_pkg.sv
// Shared encodings for the flash request scheduler.
// Command codes, FSM states and the flash address width.
package flash_pkg;

    localparam int ADDR_W = 24;

    typedef enum logic [1:0] {
        CMD_READ = 2'b00,
        CMD_PP   = 2'b01,
        CMD_SE   = 2'b10,
        CMD_BE   = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_GAP,
        ST_DONE
    } state_e;

    function automatic logic is_single(input cmd_e c);
        return (c == CMD_SE) || (c == CMD_BE);
    endfunction

endpackage

// File: rtl/flash_req_arb.sv
// Two-client round-robin scheduler in front of flash_ctrl.
// Splits READ/PP bursts into single-byte transactions.
module flash_req_arb
    import flash_pkg::*;
#(
    parameter int N     = 2,
    parameter int LEN_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N-1:0]        cl_req,
    input  logic [2*N-1:0]      cl_cmd,
    input  logic [ADDR_W*N-1:0] cl_addr,
    input  logic [LEN_W*N-1:0]  cl_len,
    input  logic [8*N-1:0]      cl_wdata,
    output logic [N-1:0]        cl_wrd,
    output logic [N-1:0]        cl_rvalid,
    output logic [7:0]          cl_rdata,
    output logic [N-1:0]        cl_done,
    output logic                busy,
    output logic                rd_req,
    output logic                pp_req,
    output logic                se_req,
    output logic                be_req,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [ADDR_W-1:0]   se_addr,
    output logic [7:0]          data_into_flash,
    input  logic                flash_ack,
    input  logic [7:0]          rdata
);

    localparam logic [N-1:0] ONE = 1;

    state_e              state_q;
    cmd_e                cmd_q;
    logic                g_q;
    logic                ptr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    cnt_q;

    logic                pick;
    cmd_e                pick_cmd;
    logic [ADDR_W-1:0]   pick_addr;
    logic [LEN_W-1:0]    pick_len;
    logic [7:0]          g_wdata;

    // The pointer names the preferred client; the other wins only if it is alone.
    assign pick      = cl_req[ptr_q] ? ptr_q : ~ptr_q;
    assign pick_cmd  = cmd_e'(pick ? cl_cmd[3:2] : cl_cmd[1:0]);
    assign pick_addr = pick ? cl_addr[ADDR_W +: ADDR_W] : cl_addr[0 +: ADDR_W];
    assign pick_len  = pick ? cl_len[LEN_W +: LEN_W] : cl_len[0 +: LEN_W];
    assign g_wdata   = g_q ? cl_wdata[15:8] : cl_wdata[7:0];

    assign rd_addr = addr_q;
    assign wr_addr = addr_q;
    assign se_addr = addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cmd_q           <= CMD_READ;
            g_q             <= 1'b0;
            ptr_q           <= 1'b0;
            addr_q          <= '0;
            cnt_q           <= '0;
            cl_wrd          <= '0;
            cl_rvalid       <= '0;
            cl_rdata        <= '0;
            cl_done         <= '0;
            busy            <= 1'b0;
            rd_req          <= 1'b0;
            pp_req          <= 1'b0;
            se_req          <= 1'b0;
            be_req          <= 1'b0;
            data_into_flash <= '0;
        end else begin
            cl_wrd    <= '0;
            cl_rvalid <= '0;
            cl_done   <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|cl_req) begin
                        g_q     <= pick;
                        cmd_q   <= pick_cmd;
                        addr_q  <= pick_addr;
                        cnt_q   <= pick_len;
                        busy    <= 1'b1;
                        state_q <= ST_ISSUE;
                        if (pick_cmd == CMD_PP)
                            cl_wrd <= ONE << pick;
                    end
                end
                ST_ISSUE: begin
                    rd_req  <= (cmd_q == CMD_READ);
                    pp_req  <= (cmd_q == CMD_PP);
                    se_req  <= (cmd_q == CMD_SE);
                    be_req  <= (cmd_q == CMD_BE);
                    if (cmd_q == CMD_PP)
                        data_into_flash <= g_wdata;
                    state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (flash_ack) begin
                        rd_req <= 1'b0;
                        pp_req <= 1'b0;
                        se_req <= 1'b0;
                        be_req <= 1'b0;
                        if (cmd_q == CMD_READ) begin
                            cl_rdata       <= rdata;
                            cl_rvalid[g_q] <= 1'b1;
                        end
                        if (cnt_q == '0 || is_single(cmd_q)) begin
                            cl_done[g_q] <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            cnt_q   <= cnt_q - 1'b1;
                            addr_q  <= addr_q + 1'b1;
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    state_q <= ST_ISSUE;
                    if (cmd_q == CMD_PP)
                        cl_wrd <= ONE << g_q;
                end
                ST_DONE: begin
                    ptr_q   <= ~g_q;
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_req_arb.sv
// Scoreboard bench for flash_req_arb with a small flash_ctrl model.
// Expected transactions, read strobes and completions are queued up front.
module tb_flash_req_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  cl_req;
    logic [3:0]  cl_cmd;
    logic [47:0] cl_addr;
    logic [15:0] cl_len;
    logic [15:0] cl_wdata;
    logic [1:0]  cl_wrd, cl_rvalid, cl_done;
    logic [7:0]  cl_rdata;
    logic        busy, rd_req, pp_req, se_req, be_req;
    logic [23:0] rd_addr, wr_addr, se_addr;
    logic [7:0]  data_into_flash;
    logic        flash_ack;
    logic [7:0]  rdata;

    flash_req_arb dut (
        .clk(clk), .reset_n(reset_n),
        .cl_req(cl_req), .cl_cmd(cl_cmd), .cl_addr(cl_addr),
        .cl_len(cl_len), .cl_wdata(cl_wdata), .cl_wrd(cl_wrd),
        .cl_rvalid(cl_rvalid), .cl_rdata(cl_rdata), .cl_done(cl_done),
        .busy(busy), .rd_req(rd_req), .pp_req(pp_req),
        .se_req(se_req), .be_req(be_req), .rd_addr(rd_addr),
        .wr_addr(wr_addr), .se_addr(se_addr),
        .data_into_flash(data_into_flash),
        .flash_ack(flash_ack), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [23:0] addr;
        logic [7:0]  data;
    } txn_t;
    typedef struct {
        int         c;
        logic [7:0] data;
    } rv_t;
    typedef struct {
        int   c;
        logic rv;
    } dn_t;

    txn_t exp_txn[$];
    rv_t  exp_rv[$];
    dn_t  exp_dn[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mb(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Client write FIFOs: byte k of client c is base + 0x11*k.
    logic [7:0] idx0 = 8'd0;
    logic [7:0] idx1 = 8'd0;
    logic [7:0] w0, w1;
    always_comb begin
        w0 = 8'h10 + 8'h11 * idx0;
        w1 = 8'hAA + 8'h11 * idx1;
    end
    assign cl_wdata = {w1, w0};
    always @(posedge clk) begin
        if (cl_wrd[0]) idx0 <= idx0 + 8'd1;
        if (cl_wrd[1]) idx1 <= idx1 + 8'd1;
    end

    // flash_ctrl model: ack two cycles after a request rises.
    logic spur = 1'b0;
    logic spur_gap = 1'b0;
    initial begin
        int dly;
        dly = 0;
        flash_ack = 1'b0;
        rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (flash_ack) begin
                flash_ack = spur_gap;
                spur_gap = 1'b0;
            end else if (spur) begin
                flash_ack = 1'b1;
                spur = 1'b0;
            end else if (!(rd_req | pp_req | se_req | be_req)) begin
                dly = 0;
            end else if (dly == 1) begin
                flash_ack = 1'b1;
                rdata = mb(rd_addr);
                dly = 0;
            end else begin
                dly = 1;
            end
        end
    end

    // Monitor: compares every DUT event against the queues.
    initial begin
        logic [3:0] prev, reqs;
        txn_t t;
        rv_t  r;
        dn_t  d;
        logic [23:0] a;
        prev = '0;
        forever begin
            @(negedge clk);
            reqs = {be_req, se_req, pp_req, rd_req};
            if (!reset_n) begin
                prev = '0;
            end else begin
                if ((reqs & ~prev) != 4'd0) begin
                    check("onehot", $countones(reqs), 1);
                    if (exp_txn.size() == 0) begin
                        check("unexp_txn", 1, 0);
                    end else begin
                        t = exp_txn.pop_front();
                        a = se_req ? se_addr : (pp_req ? wr_addr : rd_addr);
                        check("txn_kind", {30'd0, reqs[3] | reqs[2],
                              reqs[3] | reqs[1]}, {30'd0, t.kind});
                        check("txn_addr", {8'd0, a}, {8'd0, t.addr});
                        if (pp_req)
                            check("pp_data", {24'd0, data_into_flash},
                                  {24'd0, t.data});
                    end
                end
                prev = reqs;
                for (int c = 0; c < 2; c++) begin
                    if (cl_rvalid[c]) begin
                        if (exp_rv.size() == 0) begin
                            check("unexp_rvalid", 1, 0);
                        end else begin
                            r = exp_rv.pop_front();
                            check("rv_client", c, r.c);
                            check("rv_data", {24'd0, cl_rdata},
                                  {24'd0, r.data});
                        end
                    end
                    if (cl_done[c]) begin
                        if (exp_dn.size() == 0) begin
                            check("unexp_done", 1, 0);
                        end else begin
                            d = exp_dn.pop_front();
                            check("done_client", c, d.c);
                            check("done_with_rv", {31'd0, cl_rvalid[c]},
                                  {31'd0, d.rv});
                        end
                    end
                end
            end
        end
    end

    task automatic push_exp(input int c, input logic [1:0] cmd,
                            input logic [23:0] a, input logic [7:0] len);
        int nb;
        logic [7:0] base;
        txn_t t;
        nb = (cmd >= 2'd2) ? 1 : int'(len) + 1;
        base = (c == 1) ? idx1 : idx0;
        for (int i = 0; i < nb; i++) begin
            t.kind = cmd;
            t.addr = a + 24'(i);
            t.data = ((c == 1) ? 8'hAA : 8'h10) + 8'h11 * (base + 8'(i));
            exp_txn.push_back(t);
            if (cmd == 2'd0)
                exp_rv.push_back('{c, mb(a + 24'(i))});
        end
        exp_dn.push_back('{c, cmd == 2'd0});
    endtask

    task automatic drive(input int c, input logic [1:0] cmd,
                         input logic [23:0] a, input logic [7:0] len);
        cl_cmd[c*2 +: 2]   = cmd;
        cl_addr[c*24 +: 24] = a;
        cl_len[c*8 +: 8]   = len;
        cl_req[c]          = 1'b1;
    endtask

    task automatic wait_done(input int c);
        int n;
        n = 0;
        while (!cl_done[c] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cl_done[c]) check("done_timeout", 0, 1);
        cl_req[c] = 1'b0;
    endtask

    task automatic run(input int c, input logic [1:0] cmd,
                       input logic [23:0] a, input logic [7:0] len);
        push_exp(c, cmd, a, len);
        drive(c, cmd, a, len);
        wait_done(c);
        @(negedge clk);
    endtask

    task automatic both_twice();
        for (int k = 0; k < 2; k++) begin
            push_exp(0, 2'd0, 24'h000300 + 24'(k * 16), 8'd1);
            push_exp(1, 2'd1, 24'h000400 + 24'(k * 16), 8'd0);
            drive(0, 2'd0, 24'h000300 + 24'(k * 16), 8'd1);
            drive(1, 2'd1, 24'h000400 + 24'(k * 16), 8'd0);
            fork
                wait_done(0);
                wait_done(1);
            join
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        txn_t t;
        reset_n = 1'b0;
        cl_req  = '0;
        cl_cmd  = '0;
        cl_addr = '0;
        cl_len  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_reqs", {28'd0, be_req, se_req, pp_req, rd_req}, 0);
        check("rst_strobes", {26'd0, cl_wrd, cl_rvalid, cl_done}, 0);
        check("rst_rdata", {24'd0, cl_rdata}, 0);
        check("rst_wdata", {24'd0, data_into_flash}, 0);
        check("rst_addr", {8'd0, rd_addr}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // READ burst with request latency check.
        push_exp(0, 2'd0, 24'h000100, 8'd3);
        drive(0, 2'd0, 24'h000100, 8'd3);
        @(negedge clk);
        check("lat_t1_req", {31'd0, rd_req}, 0);
        check("lat_t1_busy", {31'd0, busy}, 1);
        @(negedge clk);
        check("lat_t2_req", {31'd0, rd_req}, 1);
        wait_done(0);
        @(negedge clk);

        // PP burst wrapping the 24-bit address.
        run(1, 2'd1, 24'hFFFFFE, 8'd2);
        check("wrd_count", {24'd0, idx1}, 3);

        both_twice();

        run(0, 2'd2, 24'h010000, 8'd5);

        // Reset during the second byte of a long READ.
        exp_txn.push_back('{2'd0, 24'h000200, 8'h00});
        exp_txn.push_back('{2'd0, 24'h000201, 8'h00});
        exp_rv.push_back('{0, mb(24'h000200)});
        drive(0, 2'd0, 24'h000200, 8'd7);
        n = 0;
        while (!(rd_req && rd_addr == 24'h000201) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("second_byte_seen", {31'd0, rd_req}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_reqs", {28'd0, be_req, se_req, pp_req, rd_req}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_done", {30'd0, cl_done}, 0);
        cl_req[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run(1, 2'd3, 24'h123456, 8'd9);

        // Stray acks in IDLE and in GAP.
        spur = 1'b1;
        repeat (4) @(negedge clk);
        check("spur_idle_busy", {31'd0, busy}, 0);
        spur_gap = 1'b1;
        run(0, 2'd0, 24'h000500, 8'd2);

        repeat (3) @(negedge clk);
        check("left_txn", exp_txn.size(), 0);
        check("left_rv", exp_rv.size(), 0);
        check("left_done", exp_dn.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/flash_req_arb.md
# flash_req_arb

Two-client scheduler in front of `flash_ctrl`, which executes exactly one single-byte flash transaction per request. It arbitrates between two requesters (for example, the boot/fetch port and the management port) and grants them round-robin. It expands each granted multi-byte read or page-program burst into a sequence of single-byte `flash_ctrl` transactions with auto-incremented addresses. Sector and bulk erase pass through as one transaction each.

## Interface
- `N`, 2: number of clients (fixed; RTL supports only 2)
- `LEN_W`, 8: burst length field width; burst = `len+1` bytes (1..256)

- `clk`  in  1  clock
- `reset_n`  in  1  reset reset_n, asynchronous, active-low; clock clk
- `cl_req`  in  N  per-client request level; held until `cl_done`
- `cl_cmd`  in  2N  per-client command: 00 READ, 01 PP, 10 SE, 11 BE
- `cl_addr`  in  24N  per-client start address
- `cl_len`  in  LEN_W*N  per-client byte count minus 1 (ignored for SE/BE)
- `cl_wdata`  in  8N  per-client write byte; must be valid in the cycle `cl_wrd` is high
- `cl_wrd`  out  N  one-cycle pop strobe for the write byte
- `cl_rvalid`  out  N  one-cycle strobe, read byte valid
- `cl_rdata`  out  8  read byte, shared across clients
- `cl_done`  out  N  one-cycle completion strobe
- `busy`  out  1  high when the FSM is not in IDLE
- `rd_req`, `pp_req`, `se_req`, `be_req`  out  1 each  downstream request levels
- `rd_addr`, `wr_addr`, `se_addr`  out  24 each  downstream addresses (all three driven from the same address register)
- `data_into_flash`  out  8  PP data byte
- `flash_ack`  in  1  downstream completion pulse
- `rdata`  in  8  downstream read byte, valid when `flash_ack` is high

## Operation
- FSM states: IDLE, ISSUE, WAIT_ACK, GAP, DONE.
- **IDLE.** If any `cl_req` is high, grant round-robin. The pointer starts at client 0 after reset; on simultaneous requests the client that was not granted most recently wins. On grant, latch cmd, addr, and len into the internal cmd/addr/cnt registers, then go to ISSUE.
- **ISSUE** (1 cycle).
  - PP: pulse `cl_wrd[g]` and register `cl_wdata[g]` into `data_into_flash`.
  - All commands: assert exactly one of `rd_req`/`pp_req`/`se_req`/`be_req`, selected by cmd.
  - Go to WAIT_ACK.
- **WAIT_ACK.** Hold the request level and the address/data stable until `flash_ack`. On `flash_ack`:
  - Drop the request in the same cycle's registered update, so the request is low from the next cycle.
  - READ: register `rdata` into `cl_rdata` and pulse `cl_rvalid[g]` on the next cycle.
  - If `cnt==0` or cmd is SE/BE, go to DONE. Otherwise decrement `cnt`, increment `addr` (24-bit, wraps from FFFFFF to 000000), and go to GAP.
- **GAP** (1 cycle, all requests low). Lets `flash_ctrl` return to idle. Go to ISSUE.
- **DONE** (1 cycle). Pulse `cl_done[g]`, move the round-robin pointer to the other client, and return to IDLE.
- Changes to `cl_req`, `cl_cmd`, `cl_addr`, or `cl_len` after grant are ignored. Deasserting `cl_req` does not abort the burst.
- A `flash_ack` received outside WAIT_ACK is ignored.

## Timing
- Reset values:
  - All outputs are 0: requests, strobes, `busy`, `cl_rdata`, `data_into_flash`.
  - Addresses are 0. FSM is in IDLE. Round-robin pointer is 0.
- Asynchronous reset mid-burst: all requests drop immediately and no `cl_done` is issued. `flash_ctrl` is reset by the same `reset_n`.
- Latency:
  - Request seen in IDLE at cycle T: downstream request high at T+2.
  - `flash_ack` at cycle A: `cl_rvalid` at A+1. The next byte's request is high at A+3. `cl_done` is at A+1 for the final byte.
- `cl_rvalid` and `cl_done` for the last read byte assert in the same cycle.
- No pipelining: at most one downstream transaction is outstanding.

## Structure
- Shared package `flash_pkg` holds:
  - command encodings (READ/PP/SE/BE),
  - FSM state encodings,
  - flash address width 24.
- No sub-module required. An optional `rr_arb2` (2-way round-robin picker, combinational plus pointer register) is allowed.

## Test plan
- Client 0 READ, addr 0x000100, len 3 → 4 `rd_req` transactions at 0x100..0x103, 4 `cl_rvalid[0]` strobes carrying model bytes, `cl_done[0]` with the last strobe.
- Client 1 PP, addr 0xFFFFFE, len 2, wdata AA/BB/CC → `pp_req` at FFFFFE, FFFFFF, 000000 carrying AA/BB/CC; 3 `cl_wrd[1]` pulses.
- Both clients request in the same cycle, twice → order is c0, c1, then c0, c1; no client is starved.
- Client 0 SE at 0x010000 with len=5 → exactly one `se_req`, `se_addr`=0x010000, one `cl_done`.
- `reset_n` pulsed low during the 2nd byte of a READ len 7 → requests are 0 immediately, no `cl_done`; a new BE then completes normally.
- Spurious `flash_ack` in IDLE/GAP → no state change, no strobes.
